// File: rtl/cp0_irq_ctrl_if.sv
// Pipeline <-> CP0 interrupt controller bus: mtc0/mfc0 register access plus
// the interrupt req/take handshake and eret.
interface cp0_irq_ctrl_if #(
    parameter int unsigned IDX_W = 2
) ();
    logic [4:0]       cp0_addr;
    logic             cp0_we;
    logic [31:0]      cp0_wdata;
    logic [31:0]      cp0_rdata;
    logic             eret;
    logic             irq_take;
    logic [31:0]      epc_in;
    logic             irq_req;
    logic [IDX_W-1:0] irq_index;
    logic [31:0]      irq_vector;

    modport master (
        output cp0_addr, cp0_we, cp0_wdata, eret, irq_take, epc_in,
        input  cp0_rdata, irq_req, irq_index, irq_vector
    );

    modport slave (
        input  cp0_addr, cp0_we, cp0_wdata, eret, irq_take, epc_in,
        output cp0_rdata, irq_req, irq_index, irq_vector
    );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller: N edge-triggered sources, fixed priority, req/take handshake.
// Define CP0_CAUSE_EN to add the read-only cause register at 0x0d.
module cp0_irq_ctrl #(
    parameter int unsigned NUM_IRQ    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0400,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    cp0_irq_ctrl_if.slave      bus,
    output logic [31:0]        epc,
    output logic               int_disable
);
    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [4:0] A_CAUSE   = 5'h0d;
    localparam logic [4:0] A_EPC     = 5'h0e;
    localparam logic [4:0] A_DISABLE = 5'h16;
    localparam logic [4:0] A_MASK    = 5'h17;
    localparam logic [4:0] A_PENDING = 5'h18;

    logic [NUM_IRQ-1:0] sync1, sync2, sync3;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending, pending_nxt;
    logic [NUM_IRQ-1:0] mask, mask_nxt;
    logic [NUM_IRQ-1:0] eligible, w1c, take_clr;
    logic               dis_nxt;
    logic [31:0]        epc_nxt;
    logic [1:0]         state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt, sel;
    logic               req;
    logic               take, hit_dis, hit_mask, hit_epc, hit_pend;

    // sync3 only serves the edge detector, so a rise is seen two edges after capture
    assign rise = sync2 & ~sync3;

    assign eligible = pending & mask & {NUM_IRQ{~int_disable}};
    assign take     = (state == ST_REQ) && bus.irq_take;
    assign hit_dis  = bus.cp0_we && (bus.cp0_addr == A_DISABLE);
    assign hit_mask = bus.cp0_we && (bus.cp0_addr == A_MASK);
    assign hit_epc  = bus.cp0_we && (bus.cp0_addr == A_EPC);
    assign hit_pend = bus.cp0_we && (bus.cp0_addr == A_PENDING);

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i]) sel = IDX_W'(i);
        end
    end

    always_comb begin
        w1c         = hit_pend ? bus.cp0_wdata[NUM_IRQ-1:0] : '0;
        take_clr    = take ? (NUM_IRQ'(1) << idx) : '0;
        pending_nxt = (pending & ~w1c & ~take_clr) | rise;
        mask_nxt    = hit_mask ? bus.cp0_wdata[NUM_IRQ-1:0] : mask;

        dis_nxt = int_disable;
        if (take)              dis_nxt = 1'b1;
        else if (hit_dis)      dis_nxt = bus.cp0_wdata[0];
        else if (bus.eret)     dis_nxt = 1'b0;

        epc_nxt = epc;
        if (take)              epc_nxt = bus.epc_in;
        else if (hit_epc)      epc_nxt = bus.cp0_wdata;

        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    state_nxt = ST_REQ;
                    idx_nxt   = sel;
                end
            end
            ST_REQ: begin
                // cancellation looks at next-cycle register values so irq_req drops with the write
                if (take)
                    state_nxt = ST_SERVICE;
                else if (!pending_nxt[idx] || !mask_nxt[idx] || dis_nxt)
                    state_nxt = ST_IDLE;
            end
            ST_SERVICE: begin
                if (bus.eret || (hit_dis && !bus.cp0_wdata[0]))
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            sync3       <= '0;
            pending     <= '0;
            mask        <= '1;
            int_disable <= 1'b1;
            epc         <= '0;
            state       <= ST_IDLE;
            idx         <= '0;
            req         <= 1'b0;
        end else begin
            sync1       <= irq_in;
            sync2       <= sync1;
            sync3       <= sync2;
            pending     <= pending_nxt;
            mask        <= mask_nxt;
            int_disable <= dis_nxt;
            epc         <= epc_nxt;
            state       <= state_nxt;
            idx         <= idx_nxt;
            req         <= (state_nxt == ST_REQ);
        end
    end

`ifdef CP0_CAUSE_EN
    logic [IDX_W-1:0] last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last_idx <= '0;
        else if (take) last_idx <= idx;
    end
`endif

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_addr)
            A_DISABLE: bus.cp0_rdata[0] = int_disable;
            A_MASK:    bus.cp0_rdata = 32'(mask);
            A_EPC:     bus.cp0_rdata = epc;
            A_PENDING: bus.cp0_rdata = 32'(pending);
`ifdef CP0_CAUSE_EN
            A_CAUSE: begin
                bus.cp0_rdata[31]        = (state == ST_SERVICE);
                bus.cp0_rdata[IDX_W+1:2] = last_idx;
            end
`endif
            default:   bus.cp0_rdata = '0;
        endcase
    end

    assign bus.irq_req    = req;
    assign bus.irq_index  = idx;
    assign bus.irq_vector = VEC_BASE + 32'(idx) * VEC_STRIDE;
endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed self-checking bench for cp0_irq_ctrl (3 sources, default vectors).
module tb_cp0_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] irq_in = '0;
    logic [31:0] epc;
    logic        int_disable;
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_fail = 0;

    cp0_irq_ctrl_if #(.IDX_W(2)) bus ();

    cp0_irq_ctrl #(
        .NUM_IRQ    (3),
        .VEC_BASE   (32'h0000_0400),
        .VEC_STRIDE (32'h0000_0200)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_in      (irq_in),
        .bus         (bus),
        .epc         (epc),
        .int_disable (int_disable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_addr  = a;
        bus.cp0_wdata = d;
        bus.cp0_we    = 1'b1;
        tick();
        bus.cp0_we    = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        check(tag, bus.cp0_rdata, exp);
    endtask

    task automatic take(input logic [31:0] pc);
        bus.irq_take = 1'b1;
        bus.epc_in   = pc;
        tick();
        bus.irq_take = 1'b0;
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [1:0] i, input logic [31:0] v);
        check({tag, "_req"}, 32'(bus.irq_req), 32'(r));
        if (r) begin
            check({tag, "_idx"}, 32'(bus.irq_index), 32'(i));
            check({tag, "_vec"}, bus.irq_vector, v);
        end
    endtask

    initial begin
        bus.cp0_addr = '0; bus.cp0_we = 1'b0; bus.cp0_wdata = '0;
        bus.eret = 1'b0; bus.irq_take = 1'b0; bus.epc_in = '0;

        // reset values
        #12;
        check("rst_req", 32'(bus.irq_req), 32'd0);
        check("rst_idx", 32'(bus.irq_index), 32'd0);
        check("rst_vec", bus.irq_vector, 32'h400);
        check("rst_epc", epc, 32'h0);
        check("rst_dis", 32'(int_disable), 32'd1);
        chk_reg("rst_mask", 5'h17, 32'h7);
        chk_reg("rst_pend", 5'h18, 32'h0);
        #8 rst_n = 1'b1;
        tick();

        // single source 0: synchronizer latency, request, take, eret
        mtc0(5'h16, 32'h0);
        check("en_dis", 32'(int_disable), 32'd0);
        irq_in = 3'b001;
        tick(2);
        chk_reg("s0_pend_early", 5'h18, 32'h0);
        tick();
        chk_reg("s0_pend", 5'h18, 32'h1);
        check("s0_req_early", 32'(bus.irq_req), 32'd0);
        tick();
        chk_req("s0", 1'b1, 2'd0, 32'h400);
        irq_in = 3'b000;
        take(32'h1C);
        check("s0_epc", epc, 32'h1C);
        check("s0_dis", 32'(int_disable), 32'd1);
        check("s0_req_off", 32'(bus.irq_req), 32'd0);
        chk_reg("s0_pend_clr", 5'h18, 32'h0);
        do_eret();
        check("s0_eret_dis", 32'(int_disable), 32'd0);

        // two sources together: priority, then lower one after eret
        irq_in = 3'b011;
        tick(4);
        chk_req("p1", 1'b1, 2'd1, 32'h600);
        irq_in = 3'b000;
        take(32'h20);
        chk_reg("p1_pend", 5'h18, 32'h1);
        do_eret();
        check("p1_eret_dis", 32'(int_disable), 32'd0);
        check("p1_eret_noreq", 32'(bus.irq_req), 32'd0);
        tick();
        chk_req("p0", 1'b1, 2'd0, 32'h400);
        take(32'h24);
        do_eret();

        // masked source, then unmask
        mtc0(5'h17, 32'h6);
        irq_in = 3'b001;
        tick(5);
        check("mask_noreq", 32'(bus.irq_req), 32'd0);
        chk_reg("mask_pend", 5'h18, 32'h1);
        irq_in = 3'b000;
        mtc0(5'h17, 32'hFFFF_FFFF);
        chk_reg("mask_read", 5'h17, 32'h7);
        tick();
        chk_req("unmask", 1'b1, 2'd0, 32'h400);
        take(32'h30);
        do_eret();

        // pending cleared via W1C during REQ cancels the request
        irq_in = 3'b100;
        tick(4);
        chk_req("s2", 1'b1, 2'd2, 32'h800);
        irq_in = 3'b000;
        mtc0(5'h18, 32'h4);
        check("w1c_req", 32'(bus.irq_req), 32'd0);
        chk_reg("w1c_pend", 5'h18, 32'h0);
        tick();
        check("w1c_idle", 32'(bus.irq_req), 32'd0);
        check("w1c_epc", epc, 32'h30);

        // unmapped register: write ignored, reads zero
        mtc0(5'h03, 32'hDEAD_BEEF);
        chk_reg("unmapped", 5'h03, 32'h0);

        // new edge on the same source in the take cycle keeps pending set
        irq_in = 3'b010;
        tick(4);
        chk_req("s1", 1'b1, 2'd1, 32'h600);
        irq_in = 3'b000;
        tick(2);
        irq_in = 3'b010;
        tick(2);
        take(32'h44);
        chk_reg("sim_pend", 5'h18, 32'h2);
        check("sim_epc", epc, 32'h44);
        do_eret();
        tick();
        chk_req("s1_again", 1'b1, 2'd1, 32'h600);
        irq_in = 3'b000;
        take(32'h48);
        do_eret();

        // reset while in SERVICE
        irq_in = 3'b100;
        tick(4);
        chk_req("s2b", 1'b1, 2'd2, 32'h800);
        take(32'h88);
`ifdef CP0_CAUSE_EN
        chk_reg("cause", 5'h0d, 32'h8000_0008);
`else
        chk_reg("cause_off", 5'h0d, 32'h0);
`endif
        rst_n = 1'b0;
        #1;
        check("arst_dis", 32'(int_disable), 32'd1);
        check("arst_epc", epc, 32'h0);
        chk_reg("arst_pend", 5'h18, 32'h0);
        check("arst_req", 32'(bus.irq_req), 32'd0);
        irq_in = 3'b000;
        tick();
        rst_n = 1'b1;
        tick(4);
        check("post_rst_req", 32'(bus.irq_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
